// File: rtl/ibex_rf_pkg.sv
// ibex_rf_pkg: shared types and helpers for the multi-port register file.
// Rev 1.0
`default_nettype none

package ibex_rf_pkg;

  typedef enum logic [0:0] {
    RfClrIdle   = 1'b0,
    RfClrActive = 1'b1
  } rf_clr_state_e;

  localparam int RfAddrW = 5;

  function automatic int rf_num_words(input bit rv32e);
    return rv32e ? 16 : 32;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_rf_clear_fsm.sv
// ibex_rf_clear_fsm: wipe sequencer, walks words 1..NumWords-1 and reports busy/done/dropped.
// Rev 1.0
`default_nettype none

module ibex_rf_clear_fsm
  import ibex_rf_pkg::*;
#(
  parameter int NumWords      = 32,
  parameter int NumWritePorts = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_req_i,
  input  logic [NumWritePorts-1:0] we_i,
  output logic                     clear_en_o,
  output logic [RfAddrW-1:0]       clear_idx_o,
  output logic                     clear_busy_o,
  output logic                     clear_done_o,
  output logic                     wr_dropped_o
);

  localparam logic [RfAddrW-1:0] LastIdx  = RfAddrW'(NumWords - 1);
  localparam logic [RfAddrW-1:0] FirstIdx = RfAddrW'(1);

  rf_clr_state_e      state_q, state_d;
  logic [RfAddrW-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               dropped_q, dropped_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    dropped_d = 1'b0;
    case (state_q)
      RfClrIdle: begin
        // A request is not acted on while a wipe is already running.
        if (clear_req_i) state_d = RfClrActive;
      end
      RfClrActive: begin
        dropped_d = |we_i;
        if (cnt_q == LastIdx) begin
          state_d = RfClrIdle;
          cnt_d   = FirstIdx;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + FirstIdx;
        end
      end
      default: state_d = RfClrIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RfClrIdle;
      cnt_q     <= FirstIdx;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
    end
  end

  assign clear_en_o   = (state_q == RfClrActive);
  assign clear_idx_o  = cnt_q;
  assign clear_busy_o = clear_en_o;
  assign clear_done_o = done_q;
  assign wr_dropped_o = dropped_q;

endmodule

`default_nettype wire

// File: rtl/ibex_register_file_mp.sv
// ibex_register_file_mp: flip-flop multi-port register file with collision priority, bypass and wipe.
// Rev 1.0
`default_nettype none

module ibex_register_file_mp
  import ibex_rf_pkg::*;
#(
  parameter bit          RV32E             = 1'b0,
  parameter int unsigned DataWidth         = 32,
  parameter int unsigned NumReadPorts      = 2,
  parameter int unsigned NumWritePorts     = 1,
  parameter bit          BypassEn          = 1'b0,
  parameter bit          DummyInstructions = 1'b0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               dummy_instr_id_i,
  input  logic [NumReadPorts*RfAddrW-1:0]    raddr_i,
  output logic [NumReadPorts*DataWidth-1:0]  rdata_o,
  input  logic [NumWritePorts*RfAddrW-1:0]   waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
  input  logic [NumWritePorts-1:0]           we_i,
  input  logic                               clear_req_i,
  output logic                               clear_busy_o,
  output logic                               clear_done_o,
  output logic                               wr_dropped_o
);

  localparam int NumWords = rf_num_words(RV32E);
  localparam int AddrW    = $clog2(NumWords);

  logic [DataWidth-1:0] mem     [NumWords];
  logic [DataWidth-1:0] wr_data [NumWords];
  logic [NumWords-1:0]  wr_en;
  logic [AddrW-1:0]     waddr   [NumWritePorts];
  logic [NumWritePorts-1:0] wr_valid;
  logic                 r0_access;
  logic                 clear_en;
  logic [RfAddrW-1:0]   clear_idx;
  logic                 unused_inputs;

  assign r0_access     = DummyInstructions && dummy_instr_id_i;
  assign unused_inputs = ^{raddr_i, waddr_i, dummy_instr_id_i};

  ibex_rf_clear_fsm #(
    .NumWords      (NumWords),
    .NumWritePorts (NumWritePorts)
  ) u_clear_fsm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_req_i  (clear_req_i),
    .we_i         (we_i),
    .clear_en_o   (clear_en),
    .clear_idx_o  (clear_idx),
    .clear_busy_o (clear_busy_o),
    .clear_done_o (clear_done_o),
    .wr_dropped_o (wr_dropped_o)
  );

  for (genvar k = 0; k < NumWritePorts; k++) begin : g_wport
    assign waddr[k]    = waddr_i[k*RfAddrW +: AddrW];
    assign wr_valid[k] = we_i[k] && !clear_en && ((waddr[k] != '0) || r0_access);
  end

  // Ports are scanned in ascending order so the highest-numbered port wins a collision.
  always_comb begin
    wr_en = '0;
    for (int w = 0; w < NumWords; w++) wr_data[w] = '0;
    for (int k = 0; k < NumWritePorts; k++) begin
      if (wr_valid[k]) begin
        wr_en[waddr[k]]   = 1'b1;
        wr_data[waddr[k]] = wdata_i[k*DataWidth +: DataWidth];
      end
    end
  end

  for (genvar w = 0; w < NumWords; w++) begin : g_word
    if (w == 0 && !DummyInstructions) begin : g_r0_const
      logic unused_r0;
      assign unused_r0 = wr_en[0] ^ (^wr_data[0]);
      assign mem[w]    = '0;
    end else begin : g_store
      logic [DataWidth-1:0] word_q;
      logic                 clr_hit;
      // The R0 storage word has no slot of its own in the walk; it rides along with word 1.
      assign clr_hit = clear_en &&
                       ((clear_idx == RfAddrW'(w)) || (w == 0 && clear_idx == RfAddrW'(1)));
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          word_q <= '0;
        end else if (clr_hit) begin
          word_q <= '0;
        end else if (wr_en[w]) begin
          word_q <= wr_data[w];
        end
      end
      assign mem[w] = word_q;
    end
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rport
    logic [AddrW-1:0]     ra;
    logic [DataWidth-1:0] rd;
    assign ra = raddr_i[p*RfAddrW +: AddrW];
    always_comb begin
      rd = ((ra == '0) && !r0_access) ? '0 : mem[ra];
      if (BypassEn) begin
        for (int k = 0; k < NumWritePorts; k++) begin
          if (wr_valid[k] && (waddr[k] == ra)) rd = wdata_i[k*DataWidth +: DataWidth];
        end
      end
    end
    assign rdata_o[p*DataWidth +: DataWidth] = rd;
  end

endmodule

`default_nettype wire

// File: doc/ibex_register_file_mp.md
Name: ibex_register_file_mp

Overview:
- Flip-flop based, parametrised multi-port integer register file; successor to the single-write, dual-read RF.
- Configurable read and write port counts, with deterministic priority when write ports collide on one address.
- Optional same-cycle write-to-read bypass.
- Built-in clear sequencer that zeroes the array on request (security wipe, context switch). Sits in the ID stage between decoder operand fetch and writeback.

Parameters:
- RV32E, 0: 1 gives 16 words (address bit 4 ignored); 0 gives 32 words.
- DataWidth, 32: register width in bits.
- NumReadPorts, 2: read port count, 1..4.
- NumWritePorts, 1: write port count, 1..2.
- BypassEn, 0: 1 lets a read see same-cycle write data combinationally.
- DummyInstructions, 0: 1 makes R0 a real storage word, writable and readable only under dummy_instr_id_i.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- dummy_instr_id_i  in  1  current instruction is a dummy
- raddr_i  in  NumReadPorts*5  packed read addresses; port p uses bits [5p+4:5p]
- rdata_o  out  NumReadPorts*DataWidth  packed read data
- waddr_i  in  NumWritePorts*5  packed write addresses
- wdata_i  in  NumWritePorts*DataWidth  packed write data
- we_i  in  NumWritePorts  per-port write enable
- clear_req_i  in  1  request a full array wipe
- clear_busy_o  out  1  wipe in progress
- clear_done_o  out  1  one-cycle pulse when the wipe completes
- wr_dropped_o  out  1  one-cycle pulse: at least one write was discarded this cycle

Behaviour:
- NumWords = RV32E ? 16 : 32. Internal address = low log2(NumWords) bits of each address field.
- Reset (rst_i high, asynchronous): all storage words = 0, FSM = IDLE, clear counter = 1. Outputs clear_busy_o, clear_done_o, wr_dropped_o = 0.
- Reads are combinational from the array.
  - Address 0 returns 0, except when DummyInstructions=1 and dummy_instr_id_i=1, where it returns the R0 storage word.
- Writes (IDLE only):
  - Word is updated at the posedge where we_i[k]=1 and waddr != 0.
  - New value is visible on reads from the following cycle.
  - A write to address 0 is discarded silently, unless DummyInstructions=1 and dummy_instr_id_i=1, in which case the R0 word is written.
- Write collision: if both ports target the same word in one cycle, port NumWritePorts-1 wins; the losing write is discarded without flagging.
- Bypass (BypassEn=1, IDLE only):
  - If a read address equals a write address with enable set this cycle (non-zero, or R0 under the dummy rule), rdata is that write's wdata.
  - The collision winner's data applies.
  - With BypassEn=0, a read returns the old value in that cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE to CLEAR when clear_req_i=1. clear_busy_o rises in the following cycle.
  - In CLEAR, one word is zeroed per cycle at index cnt, from cnt=1 to NumWords-1. The R0 word is also zeroed in the first CLEAR cycle when DummyInstructions=1.
  - A full wipe takes NumWords-1 cycles.
  - On the cycle that clears word NumWords-1: FSM returns to IDLE, clear_done_o pulses in the next cycle, clear_busy_o drops in that same next cycle, cnt returns to 1.
  - clear_req_i is ignored while in CLEAR; no restart and no queueing.
  - Reads in CLEAR return current array contents, which mixes cleared and uncleared words. No bypass in CLEAR.
- Writes in CLEAR: discarded. wr_dropped_o pulses in the cycle after any such we_i bit, i.e. it is registered.
- Simultaneous clear_req_i and we_i in IDLE: the write is performed and the clear starts next cycle, so the written word is later zeroed.
- Reset mid-clear: immediate return to IDLE with all words at 0. No clear_done_o pulse.

Decomposition:
- Package ibex_rf_pkg:
  - rf_clr_state_e {RfClrIdle, RfClrActive}
  - RfAddrW = 5
  - function rf_num_words(RV32E)
- One natural sub-module, ibex_rf_clear_fsm: state, counter, busy/done/dropped generation. It exports a clear-enable signal and a clear index.
- Array, write decode, collision priority and bypass muxing stay in the top module.

Test Plan:
- Defaults: write x5=0xDEADBEEF at cycle 0; read x5 on both ports at cycle 1 -> 0xDEADBEEF. Read x0 -> 0.
- NumWritePorts=2: port0 writes x7=0x11, port1 writes x7=0x22 in the same cycle -> next-cycle read x7 = 0x22, wr_dropped_o=0.
- BypassEn=1: write x3=0xA5A5A5A5 while reading x3 in the same cycle -> rdata = 0xA5A5A5A5 that cycle. BypassEn=0 -> old value.
- RV32E=0 with all words non-zero: pulse clear_req_i -> clear_busy_o high for 31 cycles, then clear_done_o single pulse, then all reads 0. A we_i issued mid-clear -> wr_dropped_o pulses and the target stays 0.
- Clear in progress: assert rst_i at clear cycle 10 -> all outputs 0, FSM IDLE, no done pulse. A write after reset release works normally.
- DummyInstructions=1: write x0=0x5 with dummy_instr_id_i=1 -> read x0 gives 0x5 with dummy=1 and 0 with dummy=0. RV32E=1: write address 5'h15 lands in x5.
